// File: rtl/mx_fpga_id_pkg.sv
// Shared constants and types for the FPGA identification ROM and its option loader.
package mx_fpga_id_pkg;

   localparam int unsigned ADDR_W        = 8;
   localparam int unsigned DATA_W        = 32;
   localparam int unsigned MAX_OPT_WORDS = 8;
   localparam int unsigned MASK_W        = MAX_OPT_WORDS * DATA_W;

   localparam logic [ADDR_W-1:0] FPGA_ID_TYPE_A     = 8'h00;
   localparam logic [ADDR_W-1:0] FPGA_ID_VER_A      = 8'h01;
   localparam logic [ADDR_W-1:0] FPGA_ID_DATE_A     = 8'h02;
   localparam logic [ADDR_W-1:0] FPGA_ID_TIME_A     = 8'h03;
   localparam logic [ADDR_W-1:0] FPGA_ID_STATUS_A   = 8'h04;
   localparam logic [ADDR_W-1:0] FPGA_ID_OPT_BASE_A = 8'h08;

   localparam int unsigned STATUS_LOADED_B    = 0;
   localparam int unsigned STATUS_ERR_B       = 1;
   localparam int unsigned STATUS_BUSY_B      = 2;
   localparam int unsigned STATUS_NWORDS_LSB  = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_SHIFT,
      ST_CHECK,
      ST_DONE
   } opt_state_e;

endpackage

// File: rtl/fpga_id_if.sv
// Word-addressed read port between the CSR converter (master) and the ID ROM (slave).
interface fpga_id_if;
   import mx_fpga_id_pkg::*;

   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;

   modport master (output rd_addr, input rd_data);
   modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/mx_fpga_id_opt_loader.sv
// Fetches the licence option mask over a serial link once after reset (or on reload),
// verifies the trailing XOR checksum byte and holds the result.
module mx_fpga_id_opt_loader
   import mx_fpga_id_pkg::*;
#(
   parameter int unsigned OPT_WORDS = 8,
   parameter int unsigned CLK_DIV   = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              reload_i,
   input  logic              sdi_i,
   output logic              cs_n_o,
   output logic              sclk_o,
   output logic              loaded_o,
   output logic [MASK_W-1:0] mask_c_o,
   output logic              loaded_c_o,
   output logic              err_c_o,
   output logic              busy_c_o
);

   localparam int unsigned NBITS = OPT_WORDS * DATA_W + 8;
   localparam int unsigned CNT_W = $clog2(MAX_OPT_WORDS * DATA_W + 8 + 1);
   localparam int unsigned DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   opt_state_e        state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sclk_q, sclk_d;
   logic              cs_n_q, cs_n_d;
   logic [NBITS-1:0]  shreg_q, shreg_d;
   logic [MASK_W-1:0] mask_q, mask_d, mask_commit;
   logic              loaded_q, loaded_d;
   logic              err_q, err_d;
   logic [7:0]        xsum;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         div_q    <= '0;
         cnt_q    <= '0;
         sclk_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         shreg_q  <= '0;
         mask_q   <= '0;
         loaded_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         sclk_q   <= sclk_d;
         cs_n_q   <= cs_n_d;
         shreg_q  <= shreg_d;
         mask_q   <= mask_d;
         loaded_q <= loaded_d;
         err_q    <= err_d;
      end
   end

   // Stream order is word 0 first, so word n sits 32n bits below the top of the shift register.
   always_comb begin
      xsum        = '0;
      mask_commit = '0;
      for (int unsigned i = 1; i < NBITS / 8; i++) xsum ^= shreg_q[8*i +: 8];
      for (int unsigned n = 0; n < OPT_WORDS; n++)
         mask_commit[DATA_W*n +: DATA_W] = shreg_q[NBITS-1-DATA_W*n -: DATA_W];
   end

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      cnt_d    = cnt_q;
      sclk_d   = sclk_q;
      shreg_d  = shreg_q;
      mask_d   = mask_q;
      loaded_d = loaded_q;
      err_d    = err_q;
      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_CS_SETUP;
            div_d   = '0;
         end
         ST_CS_SETUP: begin
            if (div_q == DIV_LAST) begin
               state_d = ST_SHIFT;
               div_d   = '0;
               sclk_d  = 1'b1;
               shreg_d = {shreg_q[NBITS-2:0], sdi_i};
               cnt_d   = CNT_W'(1);
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_SHIFT: begin
            if (div_q != DIV_LAST) begin
               div_d = div_q + 1'b1;
            end else begin
               div_d = '0;
               if (sclk_q) begin
                  sclk_d = 1'b0;
               end else if (cnt_q == CNT_W'(NBITS)) begin
                  state_d = ST_CHECK;
               end else begin
                  sclk_d  = 1'b1;
                  shreg_d = {shreg_q[NBITS-2:0], sdi_i};
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         ST_CHECK: begin
            state_d = ST_DONE;
            if (xsum == shreg_q[7:0]) begin
               mask_d   = mask_commit;
               loaded_d = 1'b1;
               err_d    = 1'b0;
            end else begin
               mask_d   = '0;
               loaded_d = 1'b0;
               err_d    = 1'b1;
            end
         end
         ST_DONE: begin
            if (reload_i) begin
               state_d  = ST_CS_SETUP;
               div_d    = '0;
               mask_d   = '0;
               loaded_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      cs_n_d   = !(state_d inside {ST_CS_SETUP, ST_SHIFT});
      busy_c_o = state_d inside {ST_CS_SETUP, ST_SHIFT, ST_CHECK};
   end

   // Next-state views feed the read-data register so STATUS and the pin change together.
   assign mask_c_o   = mask_d;
   assign loaded_c_o = loaded_d;
   assign err_c_o    = err_d;
   assign cs_n_o     = cs_n_q;
   assign sclk_o     = sclk_q;
   assign loaded_o   = loaded_q;

endmodule

// File: rtl/mx_fpga_id_rom.sv
// Firmware identification ROM: fixed ID words, status, and the licence option mask
// returned one cycle after the word address is presented.
module mx_fpga_id_rom
   import mx_fpga_id_pkg::*;
#(
   parameter logic [31:0] FPGA_TYPE  = 32'h0000_0000,
   parameter logic [31:0] FPGA_VER   = 32'h0000_0000,
   parameter logic [31:0] BUILD_DATE = 32'h0000_0000,
   parameter logic [31:0] BUILD_TIME = 32'h0000_0000,
   parameter int unsigned OPT_WORDS  = 8,
   parameter int unsigned CLK_DIV    = 4
) (
   input  logic     clk_i,
   input  logic     rst_n_i,
   fpga_id_if.slave fpga_id_rom_if,
   input  logic     opt_reload_i,
   output logic     opt_cs_n_o,
   output logic     opt_sclk_o,
   input  logic     opt_sdi_i,
   output logic     opt_loaded_o
);

   logic [MASK_W-1:0] mask_c;
   logic              loaded_c, err_c, busy_c;
   logic [ADDR_W-1:0] addr;
   logic [2:0]        opt_idx;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   mx_fpga_id_opt_loader #(
      .OPT_WORDS (OPT_WORDS),
      .CLK_DIV   (CLK_DIV)
   ) u_opt_loader (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .reload_i   (opt_reload_i),
      .sdi_i      (opt_sdi_i),
      .cs_n_o     (opt_cs_n_o),
      .sclk_o     (opt_sclk_o),
      .loaded_o   (opt_loaded_o),
      .mask_c_o   (mask_c),
      .loaded_c_o (loaded_c),
      .err_c_o    (err_c),
      .busy_c_o   (busy_c)
   );

   assign addr    = fpga_id_rom_if.rd_addr;
   assign opt_idx = addr[2:0];

   always_comb begin
      rd_data_d = '0;
      case (addr)
         FPGA_ID_TYPE_A: rd_data_d = FPGA_TYPE;
         FPGA_ID_VER_A:  rd_data_d = FPGA_VER;
         FPGA_ID_DATE_A: rd_data_d = BUILD_DATE;
         FPGA_ID_TIME_A: rd_data_d = BUILD_TIME;
         FPGA_ID_STATUS_A: begin
            rd_data_d[STATUS_LOADED_B]            = loaded_c;
            rd_data_d[STATUS_ERR_B]               = err_c;
            rd_data_d[STATUS_BUSY_B]              = busy_c;
            rd_data_d[STATUS_NWORDS_LSB +: 8]     = 8'(OPT_WORDS);
         end
         default: begin
            if (addr[7:3] == FPGA_ID_OPT_BASE_A[7:3] && 32'(opt_idx) < OPT_WORDS)
               rd_data_d = mask_c[{opt_idx, 5'b0} +: DATA_W];
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) rd_data_q <= '0;
      else          rd_data_q <= rd_data_d;
   end

   assign fpga_id_rom_if.rd_data = rd_data_q;

endmodule

// File: tb/tb_mx_fpga_id_rom.sv
// Directed bench for mx_fpga_id_rom with a serial licence-chip model (OPT_WORDS=2, CLK_DIV=2).
module tb_mx_fpga_id_rom;

   localparam logic [31:0] P_TYPE = 32'hE7D0_0001;
   localparam logic [31:0] P_VER  = 32'h0102_0304;
   localparam logic [31:0] P_DATE = 32'h2024_0615;
   localparam logic [31:0] P_TIME = 32'h0012_3456;
   localparam int          NB     = 72;
   localparam int          CS_LOW = 2 + 2*2*72;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic opt_reload = 1'b0;
   logic opt_cs_n, opt_sclk, opt_sdi, opt_loaded;

   fpga_id_if id_if ();

   mx_fpga_id_rom #(
      .FPGA_TYPE  (P_TYPE),
      .FPGA_VER   (P_VER),
      .BUILD_DATE (P_DATE),
      .BUILD_TIME (P_TIME),
      .OPT_WORDS  (2),
      .CLK_DIV    (2)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .fpga_id_rom_if (id_if),
      .opt_reload_i   (opt_reload),
      .opt_cs_n_o     (opt_cs_n),
      .opt_sclk_o     (opt_sclk),
      .opt_sdi_i      (opt_sdi),
      .opt_loaded_o   (opt_loaded)
   );

   always #5 clk = ~clk;

   // Licence chip: presents the MSB while selected, advances after each sclk falling edge.
   logic [NB-1:0] stream;
   int            bit_idx = 0;
   logic          sclk_prev = 1'b0;
   always @(posedge clk) begin
      if (opt_cs_n) bit_idx <= 0;
      else if (sclk_prev && !opt_sclk) bit_idx <= bit_idx + 1;
      sclk_prev <= opt_sclk;
   end
   assign opt_sdi = (bit_idx < NB) ? stream[NB-1-bit_idx] : 1'b0;

   // Length of the most recent completed chip-select low window, in clk cycles.
   int run_low = 0;
   int last_low = 0;
   always @(negedge clk) begin
      if (!opt_cs_n) run_low = run_low + 1;
      else if (run_low != 0) begin
         last_low = run_low;
         run_low  = 0;
      end
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic rd(input logic [7:0] a, input string tag, input logic [31:0] exp);
      id_if.rd_addr = a;
      @(negedge clk);
      chk(tag, id_if.rd_data, exp);
   endtask

   task automatic wait_cs_high(input string tag);
      int i;
      i = 0;
      while (opt_cs_n == 1'b0 && i < 2000) begin
         @(negedge clk);
         i++;
      end
      #1;
      chk({tag, "_cs_wait"}, 32'(opt_cs_n), 32'd1);
      chk({tag, "_cs_low_len"}, 32'(last_low), 32'(CS_LOW));
   endtask

   task automatic pulse_reload();
      opt_reload = 1'b1;
      @(negedge clk);
      opt_reload = 1'b0;
   endtask

   initial begin
      id_if.rd_addr = 8'h00;
      stream = {32'h0000_0005, 32'h8000_0000, 8'h85};
      repeat (3) @(negedge clk);
      chk("rst_rd_data", id_if.rd_data, 32'h0);
      chk("rst_cs_n", 32'(opt_cs_n), 32'd1);
      chk("rst_sclk", 32'(opt_sclk), 32'd0);
      chk("rst_loaded", 32'(opt_loaded), 32'd0);

      // Fetch 1: good checksum, address switched to 0x08 while the mask commits.
      rst_n = 1'b1;
      @(negedge clk);
      chk("type_word", id_if.rd_data, P_TYPE);
      chk("fetch_cs_low", 32'(opt_cs_n), 32'd0);
      rd(8'h05, "unmapped_05", 32'h0);
      rd(8'h08, "opt0_during_shift", 32'h0);
      rd(8'h01, "ver_word", P_VER);
      wait_cs_high("f1");
      chk("f1_check_rd", id_if.rd_data, P_VER);
      chk("f1_check_loaded", 32'(opt_loaded), 32'd0);
      chk("f1_check_sclk", 32'(opt_sclk), 32'd0);
      id_if.rd_addr = 8'h08;
      @(negedge clk);
      chk("f1_commit_rd", id_if.rd_data, 32'h0000_0005);
      chk("f1_loaded", 32'(opt_loaded), 32'd1);
      @(negedge clk);
      chk("f1_commit_hold", id_if.rd_data, 32'h0000_0005);
      rd(8'h09, "f1_opt1", 32'h8000_0000);
      rd(8'h04, "f1_status", 32'h0000_0201);
      rd(8'h0A, "opt_beyond_words", 32'h0);
      rd(8'h02, "date_word", P_DATE);
      rd(8'h03, "time_word", P_TIME);

      // Fetch 2: reload from DONE with a bad checksum.
      stream = {32'h0000_0005, 32'h8000_0000, 8'h84};
      id_if.rd_addr = 8'h08;
      pulse_reload();
      chk("f2_mask_cleared", id_if.rd_data, 32'h0);
      chk("f2_loaded_cleared", 32'(opt_loaded), 32'd0);
      chk("f2_cs_low", 32'(opt_cs_n), 32'd0);
      rd(8'h04, "f2_status_busy", 32'h0000_0204);
      wait_cs_high("f2");
      chk("f2_check_status", id_if.rd_data, 32'h0000_0204);
      @(negedge clk);
      chk("f2_status_err", id_if.rd_data, 32'h0000_0202);
      chk("f2_loaded", 32'(opt_loaded), 32'd0);
      rd(8'h08, "f2_opt0", 32'h0);
      rd(8'h09, "f2_opt1", 32'h0);

      // Fetch 3: reload keeps the error flag; a reload pulse mid-shift is ignored.
      stream = {32'h0000_0001, 32'h0000_0000, 8'h01};
      id_if.rd_addr = 8'h04;
      pulse_reload();
      chk("f3_status_busy_err", id_if.rd_data, 32'h0000_0206);
      repeat (40) @(negedge clk);
      pulse_reload();
      chk("f3_reload_ignored_cs", 32'(opt_cs_n), 32'd0);
      wait_cs_high("f3");
      @(negedge clk);
      chk("f3_status_ok", id_if.rd_data, 32'h0000_0201);
      rd(8'h08, "f3_opt0", 32'h0000_0001);
      rd(8'h09, "f3_opt1", 32'h0);

      // Fetch 4: one-cycle reset in the middle of the shift, then a clean refetch.
      stream = {32'h0000_0005, 32'h8000_0000, 8'h85};
      id_if.rd_addr = 8'h04;
      pulse_reload();
      repeat (150) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_cs_n", 32'(opt_cs_n), 32'd1);
      chk("mid_rst_sclk", 32'(opt_sclk), 32'd0);
      chk("mid_rst_status", id_if.rd_data, 32'h0);
      chk("mid_rst_loaded", 32'(opt_loaded), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("refetch_cs_low", 32'(opt_cs_n), 32'd0);
      wait_cs_high("f4");
      @(negedge clk);
      chk("f4_loaded", 32'(opt_loaded), 32'd1);
      chk("f4_status", id_if.rd_data, 32'h0000_0201);
      rd(8'h09, "f4_opt1", 32'h8000_0000);
      rd(8'h08, "f4_opt0", 32'h0000_0005);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mx_fpga_id_rom.md
# mx_fpga_id_rom

Responder (slave) end of `fpga_id_if`: returns 32-bit firmware identification words and the enabled-options bitmask for the word address driven by the CSR-side master. Fixed ID words come from build-time parameters. The options mask is fetched once after reset from an external serial licence shift-register chip, checked against a checksum byte, and then held. Sits in `mx_csr` next to the CSR-to-`fpga_id_if` converter, in the CSR clock domain.

## Interface
Parameters:
- `FPGA_TYPE`, 32'h0000_0000: design type/magic word.
- `FPGA_VER`, 32'h0000_0000: firmware version word.
- `BUILD_DATE`, 32'h0000_0000: build date, BCD YYYYMMDD.
- `BUILD_TIME`, 32'h0000_0000: build time, BCD 00HHMMSS.
- `OPT_WORDS`, 8: number of 32-bit option words; legal range 1..8.
- `CLK_DIV`, 4: `opt_sclk_o` half-period in `clk_i` cycles; must be ≥2.

Ports:
- `clk_i`, in, 1: CSR clock. Also used as `fpga_id_if` timing reference.
- `rst_n_i`, in, 1: reset, **synchronous, active-low**.
- `fpga_id_if.slave` `fpga_id_rom_if`:
  - `rd_addr`, in, 8: word address.
  - `rd_data`, out, 32: read data.
- `opt_reload_i`, in, 1: single-cycle pulse that restarts the option fetch.
- `opt_cs_n_o`, out, 1: licence chip select.
- `opt_sclk_o`, out, 1: licence serial clock; idle low.
- `opt_sdi_i`, in, 1: licence serial data, MSB first.
- `opt_loaded_o`, out, 1: options valid (fetch done, checksum OK).

## Operation
Word map (any address not listed reads 0):
- `0x00`: `FPGA_TYPE`
- `0x01`: `FPGA_VER`
- `0x02`: `BUILD_DATE`
- `0x03`: `BUILD_TIME`
- `0x04`: STATUS word:
  - bit0 loaded
  - bit1 checksum error
  - bit2 busy
  - [15:8] `OPT_WORDS`
- `0x08 + n`: option word n, for n < `OPT_WORDS`. Word n bit b corresponds to option 32n+b.

Option fetch state machine (`IDLE → CS_SETUP → SHIFT → CHECK → DONE`):
- **IDLE**: entered from reset. Moves to CS_SETUP on the first cycle with `rst_n_i`=1.
- **CS_SETUP**: `opt_cs_n_o`=0 for `CLK_DIV` cycles.
- **SHIFT**:
  - Shifts in `OPT_WORDS*32 + 8` bits.
  - `opt_sclk_o` toggles every `CLK_DIV` cycles. `opt_sdi_i` is sampled in the cycle in which `sclk` goes high.
  - Bit order: word 0 first, MSB first within each word. The final 8 bits are the checksum byte.
  - The shift register is separate from the visible mask, so option words read 0 during SHIFT.
- **CHECK**: one cycle.
  - `opt_cs_n_o`=1.
  - If the XOR of all option bytes equals the checksum byte: commit the mask, set loaded=1, error=0.
  - Otherwise: mask stays 0, loaded=0, error=1.
- **DONE**: holds.
  - `opt_reload_i` in DONE clears mask and loaded, keeps error, and enters CS_SETUP.
  - `opt_reload_i` in any other state is ignored.

Busy = state ∈ {CS_SETUP, SHIFT, CHECK}.

Bit counter width: `$clog2(8*32+8+1)`. Divider counter width: `$clog2(CLK_DIV)`.

## Timing
- Reset values:
  - `rd_data`=0
  - `opt_cs_n_o`=1
  - `opt_sclk_o`=0
  - `opt_loaded_o`=0
  - mask=0, error=0, state=IDLE
- `rd_data` is registered. It reflects `rd_addr` sampled at edge k, output after edge k, i.e. one cycle of latency. The master holds `rd_addr` static between CSR writes, so W0/W1 reads are always settled.
- If the mask commits in CHECK while address `0x08+n` is selected, `rd_data` shows the new value on the following cycle.
- First `sclk` rising edge occurs `CLK_DIV` cycles after `cs_n` falls. `sclk` returns low before `cs_n` rises.
- Total fetch length, in cycles from reset release to `opt_loaded_o`=1: 1 + `CLK_DIV` + 2·`CLK_DIV`·(`OPT_WORDS`·32+8) + 1.
- Reset asserted mid-fetch (sampled at the next edge):
  - All outputs return to reset values and the partial data is discarded.
  - The fetch restarts after release.
- `opt_loaded_o` rises in the same cycle that STATUS bit0 becomes readable.

## Structure
- Package `mx_fpga_id_pkg`:
  - word-address constants (`FPGA_ID_TYPE_A` … `FPGA_ID_OPT_BASE_A`)
  - STATUS bit positions
  - max option words constant (8)
  - fetch-state enum typedef
- Sub-module `mx_fpga_id_opt_loader`:
  - contains the FSM, `sclk` divider, shift register and checksum
  - outputs `mask[8*32-1:0]`, `loaded`, `err`, `busy`
- The top level holds only the address decode and the `rd_data` register.

## Test plan
- Reset release, `rd_addr`=0x00 with `FPGA_TYPE`=32'hE7D0_0001 → `rd_data`=32'hE7D0_0001 one cycle later. `rd_addr`=0x05 → 0.
- `OPT_WORDS`=2, `CLK_DIV`=2, serial model sends 32'h0000_0005, 32'h8000_0000, checksum 8'h85 → cs_n low for exactly 2+2·2·72 cycles. Then `opt_loaded_o`=1, word 0x08=32'h5, word 0x09=32'h8000_0000, STATUS=32'h0000_0201.
- Same stream with checksum 8'h84 → `opt_loaded_o`=0, words 0x08/0x09=0, STATUS=32'h0000_0202.
- `rst_n_i` low for 1 cycle midway through SHIFT → next cycle cs_n=1, sclk=0, STATUS bit2=0. After release, a full 72-bit fetch repeats and loads correctly.
- `opt_reload_i` pulse during SHIFT → ignored (bit count unchanged). Pulse in DONE → mask reads 0 and busy=1 next cycle, then a new fetch with 32'h1, 32'h0, 8'h01 → word 0x08=32'h1.
- `rd_addr` switched 0x01→0x08 in the same cycle the mask commits → `rd_data` shows the committed mask on the cycle after; no stale value appears later.
